move_select_decoder: RTL and testbench

Parametrised, registered successor to the board-cell enable decoder. It accepts a cell index from the input/cursor logic with a valid strobe and tracks which cells are already occupied. For each legal move it emits exactly one one-hot enable pulse toward the cell registers. Illegal moves are rejected, and a held strobe is blocked until it is released. It sits between the player-input block and the array of cell storage registers.

---
 rtl/move_select_pkg.sv | 14 +
 rtl/move_select_decoder_if.sv | 34 +++
 rtl/onehot_range_decode.sv | 20 ++
 rtl/move_select_decoder.sv | 141 ++++++++++++++
 tb/tb_move_select_decoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/move_select_pkg.sv
// Shared types and constants for the move-select decoder.
package move_select_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      REJ,
      WAIT_REL
   } state_e;

   localparam logic PLAYER_X = 1'b0;
   localparam logic PLAYER_O = 1'b1;

endpackage

// File: rtl/move_select_decoder_if.sv
// Request/enable handshake between player-input logic and the move-select decoder.
interface move_select_decoder_if #(
   parameter int unsigned NUM_CELLS = 9
) ();
   localparam int unsigned SEL_W = $clog2(NUM_CELLS);

   logic [SEL_W-1:0]     sel;
   logic                 sel_valid;
   logic                 player;
   logic [NUM_CELLS-1:0] en;
   logic                 en_player;
   logic                 accept;
   logic                 reject;

   modport master (
      output sel,
      output sel_valid,
      output player,
      input  en,
      input  en_player,
      input  accept,
      input  reject
   );

   modport slave (
      input  sel,
      input  sel_valid,
      input  player,
      output en,
      output en_player,
      output accept,
      output reject
   );
endinterface

// File: rtl/onehot_range_decode.sv
// Combinational cell-index to one-hot decode with an in-range flag.
module onehot_range_decode #(
   parameter int unsigned NUM_CELLS = 9,
   parameter int unsigned SEL_W     = $clog2(NUM_CELLS)
) (
   input  logic [SEL_W-1:0]     idx,
   output logic [NUM_CELLS-1:0] onehot,
   output logic                 in_range
);

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
         onehot[i] = (idx == SEL_W'(i));
      end
   end

   assign in_range = (32'(idx) < NUM_CELLS);

endmodule

// File: rtl/move_select_decoder.sv
// Registered move-select decoder: one one-hot enable pulse per legal, freshly-asserted request.
// Optional MOVE_SELECT_TURN_CHECK_EN adds an alternating-turn check and a turn output.
module move_select_decoder
   import move_select_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 9,
   parameter int unsigned SEL_W     = $clog2(NUM_CELLS),
   parameter int unsigned CNT_W     = $clog2(NUM_CELLS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   move_select_decoder_if.slave bus,
`ifdef MOVE_SELECT_TURN_CHECK_EN
   output logic                 turn,
`endif
   output logic [NUM_CELLS-1:0] occupied,
   output logic [CNT_W-1:0]     move_count,
   output logic                 board_full,
   output logic                 busy
);

   state_e               state_q, state_d;
   logic [NUM_CELLS-1:0] en_q, en_d;
   logic                 en_player_q, en_player_d;
   logic                 accept_q, accept_d;
   logic                 reject_q, reject_d;
   logic [NUM_CELLS-1:0] occupied_q, occupied_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 full_q, full_d;
   logic [NUM_CELLS-1:0] sel_oh;
   logic                 sel_in_range;
   logic                 turn_ok;
   logic                 legal;

   onehot_range_decode #(
      .NUM_CELLS (NUM_CELLS),
      .SEL_W     (SEL_W)
   ) u_decode (
      .idx      (bus.sel),
      .onehot   (sel_oh),
      .in_range (sel_in_range)
   );

`ifdef MOVE_SELECT_TURN_CHECK_EN
   logic turn_q, turn_d;
   assign turn_ok = (bus.player == turn_q);
   assign turn    = turn_q;
`else
   assign turn_ok = 1'b1;
`endif

   assign legal = sel_in_range && ~|(occupied_q & sel_oh) && !full_q && turn_ok;

   always_comb begin
      state_d     = state_q;
      en_d        = '0;
      en_player_d = PLAYER_X;
      accept_d    = 1'b0;
      reject_d    = 1'b0;
      occupied_d  = occupied_q;
      count_d     = count_q;
`ifdef MOVE_SELECT_TURN_CHECK_EN
      turn_d      = turn_q;
`endif
      if (clear) begin
         // A request coincident with clear is dropped and must be released first.
         occupied_d = '0;
         count_d    = '0;
         state_d    = bus.sel_valid ? WAIT_REL : IDLE;
`ifdef MOVE_SELECT_TURN_CHECK_EN
         turn_d     = PLAYER_X;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.sel_valid) begin
                  if (legal) begin
                     state_d     = ISSUE;
                     en_d        = sel_oh;
                     en_player_d = bus.player;
                     accept_d    = 1'b1;
                     occupied_d  = occupied_q | sel_oh;
                     count_d     = count_q + CNT_W'(1);
`ifdef MOVE_SELECT_TURN_CHECK_EN
                     turn_d      = ~turn_q;
`endif
                  end else begin
                     state_d  = REJ;
                     reject_d = 1'b1;
                  end
               end
            end
            ISSUE, REJ: state_d = WAIT_REL;
            WAIT_REL: begin
               if (!bus.sel_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      full_d = (count_d == CNT_W'(NUM_CELLS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         en_q        <= '0;
         en_player_q <= PLAYER_X;
         accept_q    <= 1'b0;
         reject_q    <= 1'b0;
         occupied_q  <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
`ifdef MOVE_SELECT_TURN_CHECK_EN
         turn_q      <= PLAYER_X;
`endif
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         en_player_q <= en_player_d;
         accept_q    <= accept_d;
         reject_q    <= reject_d;
         occupied_q  <= occupied_d;
         count_q     <= count_d;
         full_q      <= full_d;
`ifdef MOVE_SELECT_TURN_CHECK_EN
         turn_q      <= turn_d;
`endif
      end
   end

   assign bus.en        = en_q;
   assign bus.en_player = en_player_q;
   assign bus.accept    = accept_q;
   assign bus.reject    = reject_q;
   assign occupied      = occupied_q;
   assign move_count    = count_q;
   assign board_full    = full_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_move_select_decoder.sv
// Self-checking bench for move_select_decoder: directed test-plan cases plus randomized traffic
// checked every cycle against a behavioural board model.
module tb_move_select_decoder;

   localparam int unsigned NUM_CELLS = 9;
   localparam int unsigned SEL_W     = $clog2(NUM_CELLS);
   localparam int unsigned CNT_W     = $clog2(NUM_CELLS + 1);

   logic                 clk;
   logic                 rst;
   logic                 clear;
   logic [NUM_CELLS-1:0] occupied;
   logic [CNT_W-1:0]     move_count;
   logic                 board_full;
   logic                 busy;
`ifdef MOVE_SELECT_TURN_CHECK_EN
   logic                 turn;
`endif

   move_select_decoder_if #(.NUM_CELLS(NUM_CELLS)) bus ();

   move_select_decoder #(
      .NUM_CELLS (NUM_CELLS),
      .SEL_W     (SEL_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .bus        (bus.slave),
`ifdef MOVE_SELECT_TURN_CHECK_EN
      .turn       (turn),
`endif
      .occupied   (occupied),
      .move_count (move_count),
      .board_full (board_full),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: board contents, move total, whose turn, and whether a fresh request may be taken.
   bit                   m_occ [NUM_CELLS];
   int                   m_count;
   bit                   m_turn;
   int                   m_phase;  // 0: ready, 1: just answered, 2: waiting for release
   logic [NUM_CELLS-1:0] x_en;
   bit                   x_acc, x_rej, x_pl;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_CELLS-1:0] m_occ_vec();
      logic [NUM_CELLS-1:0] v = '0;
      for (int i = 0; i < NUM_CELLS; i++) v[i] = m_occ[i];
      return v;
   endfunction

   task automatic model_step();
      int  s;
      bit  ok;
      x_en  = '0;
      x_acc = 1'b0;
      x_rej = 1'b0;
      x_pl  = 1'b0;
      s     = int'(bus.sel);
      if (rst || clear) begin
         for (int i = 0; i < NUM_CELLS; i++) m_occ[i] = 1'b0;
         m_count = 0;
         m_turn  = 1'b0;
         m_phase = (!rst && bus.sel_valid) ? 2 : 0;
      end else if (m_phase == 0) begin
         if (bus.sel_valid) begin
            ok = (s < NUM_CELLS) && (m_count < NUM_CELLS);
            if (ok) ok = !m_occ[s];
`ifdef MOVE_SELECT_TURN_CHECK_EN
            if (bus.player != m_turn) ok = 1'b0;
`endif
            if (ok) begin
               m_occ[s] = 1'b1;
               m_count++;
               x_en[s]  = 1'b1;
               x_acc    = 1'b1;
               x_pl     = bus.player;
               m_turn   = ~m_turn;
            end else begin
               x_rej = 1'b1;
            end
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (!bus.sel_valid) begin
         m_phase = 0;
      end
   endtask

   task automatic compare_all();
      chk("en", int'(bus.en), int'(x_en));
      chk("accept", int'(bus.accept), int'(x_acc));
      chk("reject", int'(bus.reject), int'(x_rej));
      if (x_en != '0) chk("en_player", int'(bus.en_player), int'(x_pl));
      chk("occupied", int'(occupied), int'(m_occ_vec()));
      chk("move_count", int'(move_count), m_count);
      chk("board_full", int'(board_full), int'(m_count == NUM_CELLS));
      chk("busy", int'(busy), int'(m_phase != 0));
`ifdef MOVE_SELECT_TURN_CHECK_EN
      chk("turn", int'(turn), int'(m_turn));
`endif
   endtask

   // Apply inputs for one cycle, let the DUT and model take the edge, then compare.
   task automatic drive(input int s, input bit v, input bit p, input bit c, input bit r);
      bus.sel       = SEL_W'(s);
      bus.sel_valid = v;
      bus.player    = p;
      clear         = c;
      rst           = r;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic release_bus();
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int acc_cnt;
      int rej_cnt;
      int s;
      bit v, p, c, r;

      bus.sel = '0; bus.sel_valid = 1'b0; bus.player = 1'b0; clear = 1'b0; rst = 1'b1;
      m_count = 0; m_turn = 1'b0; m_phase = 0;

      drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst_en", int'(bus.en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(move_count), 0);

      // Held request to cell 4 yields exactly one pulse.
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         drive(4, 1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 0) begin
            chk("lit_en4", int'(bus.en), int'(9'b000010000));
            chk("lit_acc4", int'(bus.accept), 1);
            chk("lit_pl4", int'(bus.en_player), 0);
         end
         acc_cnt += int'(bus.accept);
      end
      chk("lit_one_accept", acc_cnt, 1);
      chk("lit_occ4", int'(occupied), int'(9'b000010000));
      chk("lit_cnt1", int'(move_count), 1);
      release_bus();

      // Repeat of an occupied cell rejects.
      drive(4, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("lit_rej_occ", int'(bus.reject), 1);
      chk("lit_rej_occ_en", int'(bus.en), 0);
      chk("lit_rej_occ_cnt", int'(move_count), 1);
      release_bus();

      // Out-of-range index rejects with no enable.
      rej_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         drive(12, 1'b1, 1'b1, 1'b0, 1'b0);
         rej_cnt += int'(bus.reject);
         chk("lit_oor_en", int'(bus.en), 0);
      end
      chk("lit_oor_rej", rej_cnt, 1);
      release_bus();

      // Fill the board, then any further request rejects.
      drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < NUM_CELLS; i++) begin
         drive(i, 1'b1, m_turn, 1'b0, 1'b0);
         release_bus();
      end
      chk("lit_cnt9", int'(move_count), 9);
      chk("lit_full", int'(board_full), 1);
      drive(2, 1'b1, m_turn, 1'b0, 1'b0);
      chk("lit_full_rej", int'(bus.reject), 1);
      release_bus();

      // Clear wins over a coincident request, which must then be released.
      drive(0, 1'b1, m_turn, 1'b1, 1'b0);
      chk("lit_clr_acc", int'(bus.accept), 0);
      chk("lit_clr_rej", int'(bus.reject), 0);
      chk("lit_clr_occ", int'(occupied), 0);
      chk("lit_clr_busy", int'(busy), 1);
      drive(0, 1'b1, m_turn, 1'b0, 1'b0);
      chk("lit_clr_hold", int'(bus.accept), 0);
      release_bus();
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lit_after_clr", int'(bus.accept), 1);
      release_bus();

`ifdef MOVE_SELECT_TURN_CHECK_EN
      drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lit_turn_wrong", int'(bus.reject), 1);
      release_bus();
      drive(1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("lit_turn_ok", int'(bus.accept), 1);
      chk("lit_turn_back", int'(turn), 0);
      release_bus();
`endif

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(0, NUM_CELLS - 1));
         v = ($urandom_range(0, 2) != 0);
         p = ($urandom_range(0, 4) == 0) ? 1'($urandom) : m_turn;
         c = ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 299) == 0);
         drive(s, v, p, c, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
